mul_sched: RTL and testbench
============================

MUL_SCHED -- requirements
Module: mul_sched

Interface
REQ-001 Parameter: W, default 16, operand/product width.
REQ-002 Parameter: NREQ, default 2, requester count (fixed at 2 for this revision).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: req0, req1  input  1 each  level request to multiply.
REQ-006 Port: a0, b0, a1, b1  input  W each  multiplicand/multiplier per requester.
REQ-007 Port: done0, done1  output  1 each  one-cycle completion pulse per requester.
REQ-008 Port: prod0, prod1  output  W each  last product per requester.
REQ-009 Port: gnt  output  2  one-hot grant, held for the whole operation.
REQ-010 Port: busy  output  1  high in any state other than IDLE.
REQ-011 Port: dp_data_in  output  W  operand bus to the add-loop datapath.
REQ-012 Port: ld_a, ld_b, ld_d, clr_d, dec  output  1 each  datapath strobes.
REQ-013 Port: eqz  input  1  datapath B-register-equals-zero flag, combinational on B.
REQ-014 Port: dp_prod  input  W  datapath accumulator value.

Function
REQ-015 FSM states: IDLE, LDA, LDB, CHK, ACC, DONE; all outputs registered or decoded from state only.
REQ-016 IDLE: if any req sampled high at an edge, grant per REQ-022, latch grantee a/b into internal operand registers, go to LDA; else stay in IDLE.
REQ-017 LDA: dp_data_in = latched a, ld_a=1; next LDB.
REQ-018 LDB: dp_data_in = latched b, ld_b=1, clr_d=1; next CHK.
REQ-019 CHK: no strobes; eqz=1 -> DONE (capture dp_prod into grantee's prod register on that edge), eqz=0 -> ACC.
REQ-020 ACC: ld_d=1 and dec=1 together for exactly one cycle; next CHK.
REQ-021 DONE: grantee's done pulses high for this one cycle; gnt cleared and last-grant updated on exit; next IDLE.
REQ-022 Arbitration: round-robin; single requester always wins; on tie, requester not served last wins; last-grant resets to 1 so req0 wins the first tie.
REQ-023 Latency: for latched b=n, done is high in cycle 2n+4 after the accepting edge (n=0 -> cycle 4).
REQ-024 dp_data_in = 0 outside LDA/LDB; at most one of ld_a/ld_b high per cycle.
REQ-025 Product wraps modulo 2^W; no overflow flag.
REQ-026 Operands are latched at grant; later changes to a/b do not affect the operation in progress.
REQ-027 req deassertion mid-operation is ignored; the operation completes and done still pulses.
REQ-028 req held high through done starts a new operation from IDLE (one idle cycle minimum between operations); arbitration re-evaluated each time.
REQ-029 prodX holds its value until that requester's next completion.

Reset
REQ-030 rst_n low forces IDLE immediately: all strobes 0, dp_data_in 0, gnt 0, busy 0, done0/done1 0, prod0/prod1 0, operand registers 0, last-grant 1.
REQ-031 Reset mid-operation aborts it with no done pulse; first edge after rst_n release samples reqs as in IDLE.

Structure
REQ-032 Package mul_pkg holds W default, the state enum type, and grant encoding constants.
REQ-033 Arbitration lives in sub-module rr_arb2 (2-way round-robin, inputs req/advance, output one-hot grant); sequencing FSM stays in mul_sched.

Verification
REQ-034 req0, a0=17, b0=5 -> exactly 1 ld_a, 1 ld_b+clr_d, 5 ld_d+dec pulses; done0 in cycle 14; prod0=85.
REQ-035 req1, a1=9, b1=0 -> no ld_d/dec pulses; done1 in cycle 4; prod1=0.
REQ-036 req0 and req1 high together after reset, (3,4) and (6,7) -> req0 served first (prod0=12), then req1 (prod1=42); next tie goes to req0.
REQ-037 a0=300, b0=300 -> prod0=24464 (90000 mod 65536).
REQ-038 rst_n pulsed low during ACC of a 17x5 operation -> all outputs 0 asynchronously, no done pulse, prod0=0.
REQ-039 a0 changed and req0 dropped one cycle after grant -> result still uses the latched operands; done0 still pulses.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the shift-free add-loop multiplier scheduler:
// default widths, FSM state encoding and one-hot grant constants.
package mul_pkg;

    localparam int W_DEF    = 16;
    localparam int NREQ_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LDA,
        ST_LDB,
        ST_CHK,
        ST_ACC,
        ST_DONE
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_0    = 2'b01;
    localparam logic [1:0] GNT_1    = 2'b10;

endpackage

// File: rtl/mul_sched_if.sv
// Control/status bus between the scheduler and the external add-loop datapath.
// The scheduler drives the operand bus and strobes; the datapath returns its
// B-equals-zero flag and accumulator value.
interface mul_dp_if
    import mul_pkg::*;
#(
    parameter int W = W_DEF
) ();

    logic [W-1:0] dp_data_in;
    logic         ld_a;
    logic         ld_b;
    logic         ld_d;
    logic         clr_d;
    logic         dec;
    logic         eqz;
    logic [W-1:0] dp_prod;

    modport master (
        output dp_data_in, ld_a, ld_b, ld_d, clr_d, dec,
        input  eqz, dp_prod
    );

    modport slave (
        input  dp_data_in, ld_a, ld_b, ld_d, clr_d, dec,
        output eqz, dp_prod
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// requester that was not served last wins. The served index is remembered
// whenever advance is high and a grant is being issued.
module rr_arb2
    import mul_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    // Grant decode from current requests and the last-served index
    always_comb begin
        grant = GNT_NONE;
        case (req)
            2'b01:   grant = GNT_0;
            2'b10:   grant = GNT_1;
            2'b11:   grant = last_q ? GNT_0 : GNT_1;
            default: grant = GNT_NONE;
        endcase
    end

    // Remember who was served when the owner releases the grant
    always_comb begin
        last_d = last_q;
        if (advance && (grant != GNT_NONE)) begin
            last_d = grant[1];
        end
    end

    // Last-served register; starts as requester 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mul_sched.sv
// Two-requester multiply scheduler. Grants one requester at a time, latches
// its operands, and sequences an external add-loop datapath (load A, load B
// and clear accumulator, then add-and-decrement until B reaches zero).
module mul_sched
    import mul_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NREQ = NREQ_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic [W-1:0]  a0,
    input  logic [W-1:0]  b0,
    input  logic [W-1:0]  a1,
    input  logic [W-1:0]  b1,
    output logic          done0,
    output logic          done1,
    output logic [W-1:0]  prod0,
    output logic [W-1:0]  prod1,
    output logic [1:0]    gnt,
    output logic          busy,
    mul_dp_if.master      dp
);

    state_t         state_q, state_d;
    logic [1:0]     gnt_q, gnt_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   prod0_q, prod0_d;
    logic [W-1:0]   prod1_q, prod1_d;

    logic [NREQ-1:0] arb_req;
    logic            arb_adv;
    logic [1:0]      arb_gnt;

    // While finishing, present only the current owner so the arbiter records it
    always_comb begin
        arb_req = {req1, req0};
        arb_adv = 1'b0;
        if (state_q == ST_DONE) begin
            arb_req = gnt_q;
            arb_adv = 1'b1;
        end
    end

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req),
        .advance (arb_adv),
        .grant   (arb_gnt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing of the add loop
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (arb_gnt != GNT_NONE) state_d = ST_LDA;
            ST_LDA:  state_d = ST_LDB;
            ST_LDB:  state_d = ST_CHK;
            ST_CHK:  state_d = dp.eqz ? ST_DONE : ST_ACC;
            ST_ACC:  state_d = ST_CHK;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant, operand latch and per-requester product capture
    always_comb begin
        gnt_d   = gnt_q;
        a_d     = a_q;
        b_d     = b_q;
        prod0_d = prod0_q;
        prod1_d = prod1_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_gnt != GNT_NONE) begin
                    gnt_d = arb_gnt;
                    a_d   = arb_gnt[1] ? a1 : a0;
                    b_d   = arb_gnt[1] ? b1 : b0;
                end
            end
            ST_CHK: begin
                if (dp.eqz) begin
                    if (gnt_q[0]) prod0_d = dp.dp_prod;
                    if (gnt_q[1]) prod1_d = dp.dp_prod;
                end
            end
            ST_DONE: gnt_d = GNT_NONE;
            default: ;
        endcase
    end

    // Grant, operand and product registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q   <= GNT_NONE;
            a_q     <= '0;
            b_q     <= '0;
            prod0_q <= '0;
            prod1_q <= '0;
        end else begin
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod0_q <= prod0_d;
            prod1_q <= prod1_d;
        end
    end

    // Strobes, operand bus and status decoded from state
    always_comb begin
        dp.dp_data_in = '0;
        dp.ld_a       = 1'b0;
        dp.ld_b       = 1'b0;
        dp.ld_d       = 1'b0;
        dp.clr_d      = 1'b0;
        dp.dec        = 1'b0;
        done0         = 1'b0;
        done1         = 1'b0;
        case (state_q)
            ST_LDA: begin
                dp.dp_data_in = a_q;
                dp.ld_a       = 1'b1;
            end
            ST_LDB: begin
                dp.dp_data_in = b_q;
                dp.ld_b       = 1'b1;
                dp.clr_d      = 1'b1;
            end
            ST_ACC: begin
                dp.ld_d = 1'b1;
                dp.dec  = 1'b1;
            end
            ST_DONE: begin
                done0 = gnt_q[0];
                done1 = gnt_q[1];
            end
            default: ;
        endcase
    end

    assign busy  = (state_q != ST_IDLE);
    assign gnt   = gnt_q;
    assign prod0 = prod0_q;
    assign prod1 = prod1_q;

endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched with a behavioural add-loop datapath model.
module tb_mul_sched;

    logic        clk;
    logic        rst_n;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;
    logic        done0, done1;
    logic [15:0] prod0, prod1;
    logic [1:0]  gnt;
    logic        busy;

    int vectors;
    int miscompares;

    mul_dp_if #(.W(16)) dp ();

    mul_sched #(.W(16), .NREQ(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0),
        .req1  (req1),
        .a0    (a0),
        .b0    (b0),
        .a1    (a1),
        .b1    (b1),
        .done0 (done0),
        .done1 (done1),
        .prod0 (prod0),
        .prod1 (prod1),
        .gnt   (gnt),
        .busy  (busy),
        .dp    (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural add-loop datapath: A, B down-counter, D accumulator
    logic [15:0] m_a, m_b, m_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a <= '0;
            m_b <= '0;
            m_d <= '0;
        end else begin
            if (dp.ld_a)  m_a <= dp.dp_data_in;
            if (dp.ld_b)  m_b <= dp.dp_data_in;
            if (dp.clr_d) m_d <= '0;
            if (dp.ld_d)  m_d <= m_d + m_a;
            if (dp.dec)   m_b <= m_b - 16'd1;
        end
    end
    assign dp.eqz     = (m_b == 16'd0);
    assign dp.dp_prod = m_d;

    // Waits for an operation to start, then follows it to its done pulse
    task automatic run_op(input int budget, input bit drop, input bit corrupt,
                          output logic [1:0] gnt_c1, output int done_cyc,
                          output logic [1:0] done_who, output int n_lda,
                          output int n_ldb, output int n_acc, output int n_bad);
        int waited;
        gnt_c1 = 2'b00; done_cyc = -1; done_who = 2'b00;
        n_lda = 0; n_ldb = 0; n_acc = 0; n_bad = 0;
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!busy && waited < 10);
        if (!busy) begin
            vectors++; miscompares++;
            $display("[TB] FAIL start_timeout busy=%0b required 1", busy);
            return;
        end
        gnt_c1 = gnt;
        if (drop) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        if (corrupt) begin
            a0 = 16'hFFFF;
            b0 = 16'd9;
        end
        for (int c = 1; c <= budget; c++) begin
            if (dp.ld_a) n_lda++;
            if (dp.ld_b && dp.clr_d) n_ldb++;
            if (dp.ld_d && dp.dec) n_acc++;
            if ((dp.ld_a && dp.ld_b) || (dp.ld_d != dp.dec) || (dp.clr_d != dp.ld_b) ||
                (!(dp.ld_a || dp.ld_b) && dp.dp_data_in != 16'd0) || !busy)
                n_bad++;
            if (done0 || done1) begin
                done_cyc = c;
                done_who = {done1, done0};
                break;
            end
            @(posedge clk); #1;
        end
        if (done_cyc < 0) begin
            vectors++; miscompares++;
            $display("[TB] FAIL done_timeout no done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        #1;
        vectors++;
        if ({busy, gnt, done0, done1, dp.ld_a, dp.ld_b, dp.ld_d, dp.clr_d, dp.dec} !== 10'd0 ||
            dp.dp_data_in !== 16'd0 || prod0 !== 16'd0 || prod1 !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs busy=%0b gnt=%b prod0=%0d prod1=%0d data=%0d required all 0",
                     busy, gnt, prod0, prod1, dp.dp_data_in);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset busy=%0b required 0", busy);
        end
    endtask

    task automatic test_tie();
        logic [1:0] g, w;
        int dc, nl, nb, na, bad;
        a0 = 16'd3; b0 = 16'd4; a1 = 16'd6; b1 = 16'd7;
        req0 = 1'b1; req1 = 1'b1;
        run_op(40, 1'b0, 1'b0, g, dc, w, nl, nb, na, bad);
        vectors++;
        if (g !== 2'b01 || dc !== 12 || w !== 2'b01 || prod0 !== 16'd12) begin
            miscompares++;
            $display("[TB] FAIL tie_first gnt=%b cyc=%0d done=%b prod0=%0d required 01/12/01/12",
                     g, dc, w, prod0);
        end
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || done0 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL tie_gap busy=%0b done0=%0b required 0/0", busy, done0);
        end
        run_op(60, 1'b0, 1'b0, g, dc, w, nl, nb, na, bad);
        vectors++;
        if (g !== 2'b10 || dc !== 18 || w !== 2'b10 || prod1 !== 16'd42 || na !== 7) begin
            miscompares++;
            $display("[TB] FAIL tie_second gnt=%b cyc=%0d done=%b prod1=%0d acc=%0d required 10/18/10/42/7",
                     g, dc, w, prod1, na);
        end
        run_op(40, 1'b1, 1'b0, g, dc, w, nl, nb, na, bad);
        vectors++;
        if (g !== 2'b01 || dc !== 12 || prod0 !== 16'd12) begin
            miscompares++;
            $display("[TB] FAIL tie_third gnt=%b cyc=%0d prod0=%0d required 01/12/12", g, dc, prod0);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_basic0();
        logic [1:0] g, w;
        int dc, nl, nb, na, bad;
        a0 = 16'd17; b0 = 16'd5; req0 = 1'b1;
        run_op(40, 1'b0, 1'b0, g, dc, w, nl, nb, na, bad);
        req0 = 1'b0;
        vectors++;
        if (nl !== 1 || nb !== 1 || na !== 5 || bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL strobes_17x5 lda=%0d ldb=%0d acc=%0d bad=%0d required 1/1/5/0",
                     nl, nb, na, bad);
        end
        vectors++;
        if (g !== 2'b01 || dc !== 14 || w !== 2'b01 || prod0 !== 16'd85) begin
            miscompares++;
            $display("[TB] FAIL result_17x5 gnt=%b cyc=%0d done=%b prod0=%0d required 01/14/01/85",
                     g, dc, w, prod0);
        end
        @(posedge clk); #1;
        vectors++;
        if (done0 !== 1'b0 || busy !== 1'b0 || gnt !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL done_single_pulse done0=%0b busy=%0b gnt=%b required 0/0/00",
                     done0, busy, gnt);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_zero1();
        logic [1:0] g, w;
        int dc, nl, nb, na, bad;
        a1 = 16'd9; b1 = 16'd0; req1 = 1'b1;
        run_op(20, 1'b1, 1'b0, g, dc, w, nl, nb, na, bad);
        vectors++;
        if (g !== 2'b10 || dc !== 4 || w !== 2'b10 || na !== 0 || prod1 !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL zero_b1 gnt=%b cyc=%0d done=%b acc=%0d prod1=%0d required 10/4/10/0/0",
                     g, dc, w, na, prod1);
        end
        vectors++;
        if (prod0 !== 16'd85) begin
            miscompares++;
            $display("[TB] FAIL prod0_hold prod0=%0d required 85", prod0);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        logic [1:0] g, w;
        int dc, nl, nb, na, bad;
        a0 = 16'd300; b0 = 16'd300; req0 = 1'b1;
        run_op(700, 1'b1, 1'b0, g, dc, w, nl, nb, na, bad);
        vectors++;
        if (dc !== 604 || prod0 !== 16'd24464 || na !== 300) begin
            miscompares++;
            $display("[TB] FAIL wrap_300x300 cyc=%0d prod0=%0d acc=%0d required 604/24464/300",
                     dc, prod0, na);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_latch();
        logic [1:0] g, w;
        int dc, nl, nb, na, bad;
        a0 = 16'd11; b0 = 16'd3; req0 = 1'b1;
        run_op(40, 1'b1, 1'b1, g, dc, w, nl, nb, na, bad);
        vectors++;
        if (dc !== 10 || w !== 2'b01 || prod0 !== 16'd33) begin
            miscompares++;
            $display("[TB] FAIL latched_operands cyc=%0d done=%b prod0=%0d required 10/01/33",
                     dc, w, prod0);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        int waited;
        bit saw_done;
        a0 = 16'd17; b0 = 16'd5; req0 = 1'b1;
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!dp.ld_d && waited < 20);
        req0 = 1'b0;
        vectors++;
        if (dp.ld_d !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reach_acc ld_d=%0b required 1", dp.ld_d);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, gnt, done0, done1, dp.ld_a, dp.ld_b, dp.ld_d, dp.clr_d, dp.dec} !== 10'd0 ||
            dp.dp_data_in !== 16'd0 || prod0 !== 16'd0 || prod1 !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset busy=%0b gnt=%b ld_d=%0b prod0=%0d prod1=%0d required all 0",
                     busy, gnt, dp.ld_d, prod0, prod1);
        end
        saw_done = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done0 || done1 || busy) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (done0 || done1 || busy) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done !== 1'b0 || prod0 !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL no_done_after_abort activity=%0b prod0=%0d required 0/0", saw_done, prod0);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_tie();
        test_basic0();
        test_zero1();
        test_wrap();
        test_latch();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
